// File: rtl/nlp_pkg.sv
// Shared definitions for the NLProc sequencer: phase encoding and default
// datapath timing constants.
package nlp_pkg;

  localparam int unsigned WORD_BYTES = 10;
  localparam int unsigned RUN_STEPS  = 10;
  localparam int unsigned ENC_LAT    = 2;
  localparam int unsigned PIPE_LAT   = 3;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ENC   = 3'd2,
    ST_RUN   = 3'd3,
    ST_DRAIN = 3'd4,
    ST_HOLD  = 3'd5
  } state_t;

  // Terminal count value for a phase of n cycles (a zero-length phase is skipped).
  function automatic int unsigned last_of(input int unsigned n);
    return (n == 0) ? 0 : n - 1;
  endfunction

endpackage

// File: rtl/nlp_phase_cnt.sv
// Phase counter: clear/increment with a terminal-count compare against a
// run-time limit, so one instance can serve several phases.
module nlp_phase_cnt #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] last,
  output logic [W-1:0] cnt,
  output logic         tc_c
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + W'(1);
    end
  end

  assign tc_c = (cnt == last);

endmodule

// File: rtl/nlp_seq_ctrl.sv
// Handshaked phase sequencer for the NLProc pipeline: gathers a key word,
// waits for encoding, steps the LSTM, drains the tail stages and holds the result.
module nlp_seq_ctrl
  import nlp_pkg::*;
#(
  parameter int unsigned WORD_BYTES = nlp_pkg::WORD_BYTES,
  parameter int unsigned RUN_STEPS  = nlp_pkg::RUN_STEPS,
  parameter int unsigned ENC_LAT    = nlp_pkg::ENC_LAT,
  parameter int unsigned PIPE_LAT   = nlp_pkg::PIPE_LAT,
  parameter int unsigned CNT_W      = nlp_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ice,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic             ls,
  output logic             shift_en,
  output logic             sce,
  output logic [CNT_W-1:0] step_idx,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             busy,
  output logic             err_short
);

  localparam logic [CNT_W-1:0] BYTE_LAST = CNT_W'(last_of(WORD_BYTES));
  localparam logic [CNT_W-1:0] ENC_LAST  = CNT_W'(last_of(ENC_LAT));
  localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(last_of(RUN_STEPS));
  localparam logic [CNT_W-1:0] PIPE_LAST = CNT_W'(last_of(PIPE_LAT));

  state_t           state, state_nxt;
  logic             accept;
  logic             byte_clr, byte_inc, byte_tc;
  logic             stp_clr, stp_inc, stp_tc;
  logic             err_nxt;
  logic [CNT_W-1:0] byte_cnt, stp_cnt, stp_last, step_nxt;

  // byte_ready is high exactly while in LOAD, so this is the accept strobe
  assign accept   = byte_valid & byte_ready;
  assign shift_en = accept;

  nlp_phase_cnt #(.W(CNT_W)) u_byte_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (byte_clr),
    .inc  (byte_inc),
    .last (BYTE_LAST),
    .cnt  (byte_cnt),
    .tc_c (byte_tc)
  );

  // Shared step/wait counter; its limit follows the current phase
  always_comb begin
    stp_last = '0;
    case (state)
      ST_ENC:   stp_last = ENC_LAST;
      ST_RUN:   stp_last = RUN_LAST;
      ST_DRAIN: stp_last = PIPE_LAST;
      default:  stp_last = '0;
    endcase
  end

  nlp_phase_cnt #(.W(CNT_W)) u_stp_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (stp_clr),
    .inc  (stp_inc),
    .last (stp_last),
    .cnt  (stp_cnt),
    .tc_c (stp_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    byte_clr  = 1'b0;
    byte_inc  = 1'b0;
    stp_clr   = 1'b0;
    stp_inc   = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ice) begin
          state_nxt = ST_LOAD;
          byte_clr  = 1'b1;
        end
      end
      ST_LOAD: begin
        // a byte accepted in the same cycle ice falls still counts
        if (accept) begin
          if (byte_tc) begin
            byte_clr  = 1'b1;
            stp_clr   = 1'b1;
            state_nxt = (ENC_LAT == 0) ? ST_RUN : ST_ENC;
          end else begin
            byte_inc = 1'b1;
          end
        end else if (!ice) begin
          byte_clr  = 1'b1;
          err_nxt   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_ENC: begin
        if (stp_tc) begin
          stp_clr   = 1'b1;
          state_nxt = ST_RUN;
        end else begin
          stp_inc = 1'b1;
        end
      end
      ST_RUN: begin
        if (stp_tc) begin
          stp_clr   = 1'b1;
          state_nxt = (PIPE_LAT == 0) ? ST_HOLD : ST_DRAIN;
        end else begin
          stp_inc = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (stp_tc) begin
          stp_clr   = 1'b1;
          state_nxt = ST_HOLD;
        end else begin
          stp_inc = 1'b1;
        end
      end
      ST_HOLD: begin
        if (res_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    step_nxt = stp_cnt;
    if (stp_clr) begin
      step_nxt = '0;
    end else if (stp_inc) begin
      step_nxt = stp_cnt + CNT_W'(1);
    end
  end

  // Outputs are registered from the next state so they align with the phase
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_ready <= 1'b0;
      ls         <= 1'b0;
      sce        <= 1'b0;
      step_idx   <= '0;
      res_valid  <= 1'b0;
      busy       <= 1'b0;
      err_short  <= 1'b0;
    end else begin
      byte_ready <= (state_nxt == ST_LOAD);
      ls         <= (state_nxt == ST_LOAD);
      sce        <= (state_nxt == ST_RUN) || (state_nxt == ST_DRAIN);
      step_idx   <= (state_nxt == ST_RUN) ? step_nxt : '0;
      res_valid  <= (state_nxt == ST_HOLD);
      busy       <= (state_nxt != ST_IDLE);
      err_short  <= err_nxt;
    end
  end

endmodule

// File: tb/tb_nlp_seq_ctrl.sv
// Self-checking bench for nlp_seq_ctrl: each word's expected waveform is
// derived from a timeline anchored at the cycle of the last accepted byte.
module tb_nlp_seq_ctrl;

  localparam int WB = 10;
  localparam int RS = 10;
  localparam int EL = 2;
  localparam int PL = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       ice;
  logic       byte_valid;
  logic       byte_ready;
  logic       ls;
  logic       shift_en;
  logic       sce;
  logic [3:0] step_idx;
  logic       res_valid;
  logic       res_ready;
  logic       busy;
  logic       err_short;

  int n_chk  = 0;
  int n_pass = 0;

  nlp_seq_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .ice        (ice),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .ls         (ls),
    .shift_en   (shift_en),
    .sce        (sce),
    .step_idx   (step_idx),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .busy       (busy),
    .err_short  (err_short)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int cyc, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s (cycle %0d): observed %0d expected %0d", tag, cyc, obs, exp);
  endtask

  task automatic chk_all(input string tag, input int cyc, input bit e_ld, input bit e_sce,
                         input int e_step, input bit e_rv, input bit e_busy,
                         input bit e_sh, input bit e_err);
    chk({tag, ".ls"}, cyc, 32'(ls), 32'(e_ld));
    chk({tag, ".byte_ready"}, cyc, 32'(byte_ready), 32'(e_ld));
    chk({tag, ".shift_en"}, cyc, 32'(shift_en), 32'(e_sh));
    chk({tag, ".sce"}, cyc, 32'(sce), 32'(e_sce));
    chk({tag, ".step_idx"}, cyc, 32'(step_idx), 32'(e_step));
    chk({tag, ".res_valid"}, cyc, 32'(res_valid), 32'(e_rv));
    chk({tag, ".busy"}, cyc, 32'(busy), 32'(e_busy));
    chk({tag, ".err_short"}, cyc, 32'(err_short), 32'(e_err));
  endtask

  // One complete word. Precondition: ice=1 was just driven in an IDLE cycle.
  // Timeline from the cycle a of the last accept: ENC a+1.., RUN a+EL+1..,
  // DRAIN after RS steps, HOLD from h until res_ready after bp stall cycles.
  task automatic run_word(input string tag, input int gap_pct, input int bp,
                          input bit keep_ice, input bit drop_ice_last);
    bit vpat[64];
    int ones = 0;
    int a = 0;
    int h, last;
    int sce_n = 0;
    for (int i = 0; i < 64; i++) vpat[i] = 1'b0;
    for (int i = 0; i < 64 && ones < WB; i++) begin
      vpat[i] = (i >= 40) || ($urandom_range(99) >= 32'(gap_pct));
      if (vpat[i]) begin
        ones++;
        a = i;
      end
    end
    h    = a + EL + RS + PL + 1;
    last = h + bp + 1;
    for (int c = 0; c <= last; c++) begin
      bit e_ld, e_sce, e_rv, e_busy, e_sh;
      int e_step;
      @(negedge clk);
      if (c <= a) begin
        byte_valid = vpat[c];
        ice        = !(drop_ice_last && c == a);
      end else begin
        byte_valid = 1'($urandom_range(1));
        ice        = (c < h + bp) ? 1'($urandom_range(1)) : keep_ice;
      end
      if (c < h)            res_ready = 1'($urandom_range(1));
      else if (c == h + bp) res_ready = 1'b1;
      else                  res_ready = 1'b0;
      #1;
      e_ld   = (c <= a);
      e_sh   = e_ld && vpat[c];
      e_sce  = (c > a + EL) && (c < h);
      e_step = (c > a + EL && c <= a + EL + RS) ? c - (a + EL + 1) : 0;
      e_rv   = (c >= h) && (c <= h + bp);
      e_busy = (c < last);
      chk_all(tag, c, e_ld, e_sce, e_step, e_rv, e_busy, e_sh, 1'b0);
      if (sce === 1'b1) sce_n++;
    end
    chk({tag, ".sce_total"}, last, 32'(sce_n), 32'(RS + PL));
  endtask

  initial begin
    bit found;
    rst        = 1'b1;
    ice        = 1'b0;
    byte_valid = 1'b0;
    res_ready  = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk_all("reset", 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_all("idle", 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Nominal back-to-back bytes, short result hold
    @(negedge clk);
    ice = 1'b1;
    run_word("nominal", 0, 0, 1'b0, 1'b0);

    // Gapped bytes, random hold
    @(negedge clk);
    ice = 1'b1;
    run_word("gapped", 50, $urandom_range(5), 1'b0, 1'b0);

    // Abort after 4 bytes
    @(negedge clk);
    ice = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      byte_valid = 1'b1;
      #1;
      chk_all("abort.load", c, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    end
    @(negedge clk);
    byte_valid = 1'b0;
    ice        = 1'b0;
    #1;
    chk_all("abort.drop", 4, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    chk_all("abort.err", 5, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    #1;
    chk_all("abort.after", 6, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

    // New word after abort, then backpressure of 20 cycles
    @(negedge clk);
    ice = 1'b1;
    run_word("post_abort", 30, 2, 1'b0, 1'b0);
    @(negedge clk);
    ice = 1'b1;
    run_word("backpressure", 20, 20, 1'b0, 1'b0);

    // Last byte coincides with ice falling; ice then held high for chained words
    @(negedge clk);
    ice = 1'b1;
    run_word("coincide", 40, 1, 1'b1, 1'b1);
    run_word("chain1", 25, 0, 1'b1, 1'b0);
    run_word("chain2", 60, $urandom_range(8), 1'b0, 1'b0);

    // Reset mid-RUN at step 5
    @(negedge clk);
    ice = 1'b1;
    for (int c = 0; c < WB; c++) begin
      @(negedge clk);
      byte_valid = 1'b1;
    end
    @(negedge clk);
    byte_valid = 1'b0;
    ice        = 1'b0;
    found      = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      #1;
      if (sce === 1'b1 && step_idx === 4'd5) found = 1'b1;
    end
    chk("rst_run.reached_step5", 0, 32'(found), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ice = 1'b1;
    #1;
    chk_all("rst_run.after", 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    ice = 1'b0;
    #1;
    chk_all("rst_run.load", 1, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    chk_all("rst_run.empty_abort", 2, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Random words to finish
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      ice = 1'b1;
      run_word("random", $urandom_range(70), $urandom_range(6), 1'b0, 1'($urandom_range(1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
